// File: rtl/conv_mem_pkg.sv
// Shared constants, bank-select encodings and FSM states for the CONV memory responder.
package conv_mem_pkg;

    localparam int DATA_W    = 20;
    localparam int ADDR_W    = 12;
    localparam int IMG_DEPTH = 4096;
    localparam int L1_DEPTH  = 1024;
    localparam int L2_DEPTH  = 2048;
    localparam int NUM_BANKS = 6;

    typedef enum logic [2:0] {
        NO_MEM    = 3'b000,
        MEM_L0_C0 = 3'b001,
        MEM_L0_C1 = 3'b010,
        MEM_L1_C0 = 3'b011,
        MEM_L1_C1 = 3'b100,
        MEM_L2    = 3'b101
    } csel_e;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_READY,
        ST_RUN,
        ST_DONE
    } state_e;

    // Number of addressable words behind a select code; zero means "no bank".
    // The debug port treats code 000 as the image, the layer ports do not.
    function automatic logic [ADDR_W:0] bank_depth(input logic [2:0] sel, input logic img_at_zero);
        case (csel_e'(sel))
            MEM_L0_C0, MEM_L0_C1: bank_depth = (ADDR_W+1)'(IMG_DEPTH);
            MEM_L1_C0, MEM_L1_C1: bank_depth = (ADDR_W+1)'(L1_DEPTH);
            MEM_L2:               bank_depth = (ADDR_W+1)'(L2_DEPTH);
            NO_MEM:               bank_depth = img_at_zero ? (ADDR_W+1)'(IMG_DEPTH) : '0;
            default:              bank_depth = '0;
        endcase
    endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// Synchronous-write, asynchronous-read word array with one extra read tap for debug.
module conv_bank_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 20,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/conv_mem_responder.sv
// Image and layer memories for the CONV accelerator with the load/ready/run/done handshake.
// Bank index equals the csel code; index 0 holds the image.
module conv_mem_responder
    import conv_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              ready,
    input  logic              busy,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic [2:0]        csel,
    output logic              done,
    output logic              err,
    input  logic [2:0]        dbg_sel,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic [DATA_W-1:0]    bank_rd  [NUM_BANKS];
    logic [DATA_W-1:0]    bank_dbg [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_we;
    logic [DATA_W-1:0]    rd_word, dbg_word;

    logic wr_state_ok, wr_in_range, wr_ok, rd_ok, dbg_ok, err_set;

    assign wr_state_ok = (state_q == ST_READY) || (state_q == ST_RUN);
    assign wr_in_range = {1'b0, caddr_wr} < bank_depth(csel, 1'b0);
    assign wr_ok       = cwr && wr_state_ok && wr_in_range;
    assign rd_ok       = crd && ({1'b0, caddr_rd} < bank_depth(csel, 1'b0));
    assign dbg_ok      = {1'b0, dbg_addr} < bank_depth(dbg_sel, 1'b1);
    assign err_set     = (cwr && !wr_ok) || (crd && !rd_ok);

    always_comb begin
        bank_we    = '0;
        bank_we[0] = load_valid && (state_q == ST_LOAD);
        for (int b = 1; b < NUM_BANKS; b++) begin
            bank_we[b] = wr_ok && (csel == 3'(b));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        localparam int DEPTH = (g == 3 || g == 4) ? L1_DEPTH : (g == 5) ? L2_DEPTH : IMG_DEPTH;
        localparam int AW    = $clog2(DEPTH);

        logic [AW-1:0]     waddr, raddr;
        logic [DATA_W-1:0] wdata;

        assign waddr = (g == 0) ? load_addr[AW-1:0] : caddr_wr[AW-1:0];
        assign raddr = (g == 0) ? iaddr[AW-1:0]     : caddr_rd[AW-1:0];
        assign wdata = (g == 0) ? load_data         : cdata_wr;

        conv_bank_ram #(
            .DEPTH (DEPTH),
            .WIDTH (DATA_W)
        ) u_ram (
            .clk        (clk),
            .we_i       (bank_we[g]),
            .waddr_i    (waddr),
            .wdata_i    (wdata),
            .raddr_i    (raddr),
            .rdata_o    (bank_rd[g]),
            .dbg_addr_i (dbg_addr[AW-1:0]),
            .dbg_data_o (bank_dbg[g])
        );
    end

    always_comb begin
        rd_word  = '0;
        dbg_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (csel == 3'(b)) rd_word = bank_rd[b];
            if (dbg_sel == 3'(b)) dbg_word = bank_dbg[b];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (load_valid && load_last) state_d = ST_READY;
            ST_READY: if (busy) state_d = ST_RUN;
            ST_RUN:   if (busy_q && !busy) state_d = ST_DONE;
            ST_DONE:  if (load_valid) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
        ready_d = (state_d == ST_READY);
        done_d  = (state_d == ST_DONE);
        err_d   = err_q || err_set;
        // Flatten writes back the last word read, so hold it across non-read cycles.
        hold_d  = rd_ok ? rd_word : hold_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy;
            hold_q  <= hold_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign err      = err_q;
    assign idata    = bank_rd[0];
    assign cdata_rd = crd ? (rd_ok ? rd_word : '0) : hold_q;
    assign dbg_data = dbg_ok ? dbg_word : '0;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized bench for conv_mem_responder: a phase/array model checked every negedge plus literal pins.
module tb_conv_mem_responder;

    localparam int P_LOAD  = 0;
    localparam int P_READY = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0, load_last = 1'b0, busy = 1'b0, cwr = 1'b0, crd = 1'b0;
    logic [11:0] load_addr = '0, iaddr = '0, caddr_wr = '0, caddr_rd = '0, dbg_addr = '0;
    logic [19:0] load_data = '0, cdata_wr = '0;
    logic [2:0]  csel = '0, dbg_sel = '0;
    logic        ready, done, err;
    logic [19:0] idata, cdata_rd, dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    int          ph = P_LOAD;
    bit          m_err = 0, m_prev_busy = 0, m_hold_val = 1;
    logic [19:0] m_hold = '0;
    logic [19:0] m_mem [6][4096];
    bit          m_val [6][4096];

    always #5 clk = ~clk;

    conv_mem_responder dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .done(done), .err(err), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic int lay_depth(input int s);
        case (s)
            1, 2:    return 4096;
            3, 4:    return 1024;
            5:       return 2048;
            default: return 0;
        endcase
    endfunction

    function automatic int dbg_depth(input int s);
        return (s == 0) ? 4096 : lay_depth(s);
    endfunction

    function automatic logic [19:0] pat(input int s, input int a);
        if (s == 2 && a == 7) return 20'h00000;
        if (s == 3 && a == 5) return 20'h00A00;
        return 20'((s << 16) | a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int d;
        bit run_ok, r_ok, w_ok;
        run_ok = (ph == P_READY) || (ph == P_RUN);
        d      = lay_depth(int'(csel));
        r_ok   = crd && (int'(caddr_rd) < d);
        w_ok   = cwr && run_ok && (int'(caddr_wr) < d);
        if ((cwr && !w_ok) || (crd && !r_ok)) m_err = 1;
        if (r_ok) begin
            m_hold     = m_mem[csel][caddr_rd];
            m_hold_val = m_val[csel][caddr_rd];
        end
        if (w_ok) begin
            m_mem[csel][caddr_wr] = cdata_wr;
            m_val[csel][caddr_wr] = 1;
        end
        if (ph == P_LOAD && load_valid) begin
            m_mem[0][load_addr] = load_data;
            m_val[0][load_addr] = 1;
        end
        case (ph)
            P_LOAD:  if (load_valid && load_last) ph = P_READY;
            P_READY: if (busy) ph = P_RUN;
            P_RUN:   if (m_prev_busy && !busy) ph = P_DONE;
            P_DONE:  if (load_valid) ph = P_LOAD;
            default: ph = P_LOAD;
        endcase
        m_prev_busy = busy;
    endtask

    task automatic cmp_step();
        int d;
        logic [19:0] e;
        bit k;
        chk("ready", 32'(ready), 32'(ph == P_READY));
        chk("done", 32'(done), 32'(ph == P_DONE));
        chk("err", 32'(err), 32'(m_err));
        if (m_val[0][iaddr]) chk("idata", 32'(idata), 32'(m_mem[0][iaddr]));
        d = lay_depth(int'(csel));
        if (crd) begin
            if (int'(caddr_rd) < d) begin
                e = m_mem[csel][caddr_rd];
                k = m_val[csel][caddr_rd];
            end else begin
                e = '0;
                k = 1;
            end
        end else begin
            e = m_hold;
            k = m_hold_val;
        end
        if (k) chk("cdata_rd", 32'(cdata_rd), 32'(e));
        d = dbg_depth(int'(dbg_sel));
        if (int'(dbg_addr) < d) begin
            e = m_mem[dbg_sel][dbg_addr];
            k = m_val[dbg_sel][dbg_addr];
        end else begin
            e = '0;
            k = 1;
        end
        if (k) chk("dbg_data", 32'(dbg_data), 32'(e));
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                ph          = P_LOAD;
                m_err       = 0;
                m_prev_busy = 0;
                m_hold      = '0;
                m_hold_val  = 1;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cmp_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        iaddr    = 12'($urandom);
        dbg_sel  = 3'($urandom);
        dbg_addr = 12'($urandom);
    endtask

    initial begin
        int s, d, hi;
        repeat (3) tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4096; i++) begin
            load_valid = 1'b1;
            load_addr  = 12'(i);
            load_data  = 20'(i);
            load_last  = (i == 4095);
            if (i == 4095) chk("ready_before_last", 32'(ready), 32'd0);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("ready_after_load", 32'(ready), 32'd1);
        iaddr = 12'd65;
        #1 chk("idata_65", 32'(idata), 32'd65);

        // Give every layer word a known value before any read traffic.
        for (int sb = 1; sb <= 5; sb++) begin
            for (int a = 0; a < lay_depth(sb); a++) begin
                cwr      = 1'b1;
                csel     = 3'(sb);
                caddr_wr = 12'(a);
                cdata_wr = pat(sb, a);
                tick();
            end
        end
        cwr = 1'b0;
        chk("ready_held", 32'(ready), 32'd1);

        busy = 1'b1;
        tick();
        chk("ready_drop", 32'(ready), 32'd0);

        cwr = 1'b1; csel = 3'd1; caddr_wr = 12'd10; cdata_wr = 20'h12345;
        tick();
        cwr = 1'b0; dbg_sel = 3'd1; dbg_addr = 12'd10;
        #1 chk("dbg_l0k0_10", 32'(dbg_data), 32'h12345);

        crd = 1'b1; csel = 3'd3; caddr_rd = 12'd5;
        #1 chk("rd_l1k0_5", 32'(cdata_rd), 32'h00A00);
        tick();
        crd = 1'b0; csel = 3'd5;
        #1 chk("hold_after_read", 32'(cdata_rd), 32'h00A00);
        cwr = 1'b1; caddr_wr = 12'd0; cdata_wr = 20'h00A00;
        tick();
        cwr = 1'b0; dbg_sel = 3'd5; dbg_addr = 12'd0;
        #1 chk("l2_0_flatten", 32'(dbg_data), 32'h00A00);

        cwr = 1'b1; crd = 1'b1; csel = 3'd2; caddr_wr = 12'd7; caddr_rd = 12'd7; cdata_wr = 20'h00001;
        #1 chk("collide_old", 32'(cdata_rd), 32'h0);
        tick();
        cwr = 1'b0;
        #1 chk("collide_new", 32'(cdata_rd), 32'h1);
        crd = 1'b0;

        chk("err_before", 32'(err), 32'd0);
        cwr = 1'b1; csel = 3'd6; caddr_wr = 12'd3; cdata_wr = 20'hABCDE;
        tick();
        cwr = 1'b0;
        chk("err_bad_sel", 32'(err), 32'd1);
        cwr = 1'b1; csel = 3'd3; caddr_wr = 12'd1024; cdata_wr = 20'hFFFFF;
        tick();
        cwr = 1'b0; dbg_sel = 3'd3; dbg_addr = 12'd0;
        #1 chk("l1_oob_nowrite", 32'(dbg_data), 32'h30000);

        for (int n = 0; n < 1500; n++) begin
            s  = ($urandom % 8 == 0) ? int'($urandom % 8) : int'($urandom_range(1, 5));
            d  = lay_depth(s);
            hi = (d == 0 || d + 7 > 4095) ? 4095 : d + 7;
            cwr      = 1'($urandom);
            crd      = 1'($urandom);
            csel     = 3'(s);
            caddr_wr = 12'($urandom_range(16, hi));
            caddr_rd = 12'($urandom_range(0, hi));
            cdata_wr = 20'($urandom);
            tick();
        end
        cwr = 1'b0;
        crd = 1'b0;

        busy = 1'b0;
        tick();
        chk("done_set", 32'(done), 32'd1);
        chk("err_kept_done", 32'(err), 32'd1);
        tick();
        chk("done_held", 32'(done), 32'd1);

        load_valid = 1'b1; load_addr = 12'd0; load_data = 20'd7;
        tick();
        load_valid = 1'b0;
        chk("done_clr", 32'(done), 32'd0);
        chk("err_after_reload", 32'(err), 32'd1);
        iaddr = 12'd0;
        #1 chk("done_load_nowrite", 32'(idata), 32'd0);

        load_valid = 1'b1; load_last = 1'b1; load_addr = 12'd1; load_data = 20'h00077;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("ready_reload", 32'(ready), 32'd1);
        iaddr = 12'd1;
        #1 chk("idata_reload", 32'(idata), 32'h00077);

        busy = 1'b1;
        tick();
        tick();
        chk("ready_run", 32'(ready), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("midrun_rst_ready", 32'(ready), 32'd0);
        chk("midrun_rst_done", 32'(done), 32'd0);
        chk("midrun_rst_err", 32'(err), 32'd0);
        dbg_sel = 3'd1; dbg_addr = 12'd10;
        #1 chk("mem_retained", 32'(dbg_data), 32'h12345);

        tick();
        reset = 1'b0;
        busy  = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("ready_stays_low", 32'(ready), 32'd0);
        end
        load_valid = 1'b1; load_last = 1'b1; load_addr = 12'd2; load_data = 20'd5;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("ready_after_relast", 32'(ready), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
